// File: rtl/keyproc_gen_if.sv
// Key-processor bundle: raw buttons in, debounced levels and instruction code out.
// The master side drives the buttons; the slave side is the key processor.
interface keyproc_gen_if #(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W   = 3
);
  logic [NUM_KEYS-1:0] keys;
  logic [CODE_W-1:0]   instruction;
  logic                instr_pulse;
  logic [NUM_KEYS-1:0] key_state;

  modport master (output keys, input instruction, input instr_pulse, input key_state);
  modport slave  (input keys, output instruction, output instr_pulse, output key_state);
endinterface

// File: rtl/keyproc_gen.sv
// Synchronise, debounce and priority-encode NUM_KEYS push buttons into an instruction code.
// Optional auto-repeat of instr_pulse while a key is held: define KEYPROC_REPEAT_EN.
module keyproc_gen #(
  parameter int NUM_KEYS        = 4,
  parameter int CODE_W          = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic          sysclk,
  input logic          reset,
  keyproc_gen_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  generate
    if ((1 << CODE_W) <= NUM_KEYS) begin : g_bad_code_w
      $error("keyproc_gen: 2**CODE_W must exceed NUM_KEYS");
    end
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_timing
      $error("keyproc_gen: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACTIVE, LOCKOUT} state_t;

  state_t              state, state_n;
  logic [NUM_KEYS-1:0] sync1, sync2, key_state;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] sel_mask, sel_mask_n, low_mask;
  logic [CODE_W-1:0]   instruction, instr_n, low_code;
  logic                instr_pulse, pulse_n, any_key, sel_held;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.keys;
      sync2 <= sync1;
    end
  end

  // A key flips only after sync2 has disagreed with it for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      key_state <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] == key_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          key_state[i] <= ~key_state[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign any_key  = |key_state;
  assign low_mask = key_state & (~key_state + NUM_KEYS'(1));
  assign sel_held = |(key_state & sel_mask);

  always_comb begin
    low_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_state[i]) low_code = CODE_W'(i + 1);
    end
  end

`ifdef KEYPROC_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
  logic             rep_first, rep_first_n, rep_due;

  // The first repeat waits REPEAT_DELAY after the entry pulse, later ones REPEAT_PERIOD.
  assign rep_due = (rep_cnt == (rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1)));

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt_n;
      rep_first <= rep_first_n;
    end
  end
`endif

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel_mask    <= '0;
      instruction <= '0;
      instr_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      sel_mask    <= sel_mask_n;
      instruction <= instr_n;
      instr_pulse <= pulse_n;
    end
  end

  // Once a key is accepted it owns the output until released; nothing preempts it.
  always_comb begin
    state_n    = state;
    sel_mask_n = sel_mask;
    instr_n    = instruction;
    pulse_n    = 1'b0;
`ifdef KEYPROC_REPEAT_EN
    rep_cnt_n   = '0;
    rep_first_n = 1'b1;
`endif
    case (state)
      IDLE: begin
        instr_n = '0;
        if (any_key) begin
          sel_mask_n = low_mask;
          instr_n    = low_code;
          pulse_n    = 1'b1;
          state_n    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sel_held) begin
`ifdef KEYPROC_REPEAT_EN
          if (rep_due) begin
            pulse_n     = 1'b1;
            rep_cnt_n   = '0;
            rep_first_n = 1'b0;
          end else begin
            rep_cnt_n   = rep_cnt + 1'b1;
            rep_first_n = rep_first;
          end
`endif
        end else begin
          instr_n = '0;
          state_n = any_key ? LOCKOUT : IDLE;
        end
      end
      LOCKOUT: begin
        instr_n = '0;
        if (!any_key) state_n = IDLE;
      end
      default: begin
        instr_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.key_state   = key_state;
  assign bus.instruction = instruction;
  assign bus.instr_pulse = instr_pulse;

endmodule

// File: tb/tb_keyproc_gen.sv
// Directed bench for keyproc_gen with short debounce/repeat timing and a 7-key width instance.
// Expectations for pulse counts switch on KEYPROC_REPEAT_EN.
module tb_keyproc_gen;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pulse_cnt = 0;
  int   pulse_q[$];

  keyproc_gen_if #(.NUM_KEYS(4), .CODE_W(3)) bus ();
  keyproc_gen_if #(.NUM_KEYS(7), .CODE_W(3)) bus7 ();

  keyproc_gen #(.NUM_KEYS(4), .CODE_W(3), .DEBOUNCE_CYCLES(4),
                .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .sysclk(sysclk), .reset(reset), .bus(bus.slave));

  keyproc_gen #(.NUM_KEYS(7), .CODE_W(3), .DEBOUNCE_CYCLES(4),
                .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut7 (
    .sysclk(sysclk), .reset(reset), .bus(bus7.slave));

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Pulses are tallied mid-cycle so each one-cycle strobe is seen exactly once.
  always @(negedge sysclk) begin
    if (bus.instr_pulse) begin
      pulse_cnt++;
      pulse_q.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] k, input int cycles);
    bus.keys = k;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    int exp_rep[5] = '{0, 20, 28, 36, 44};
    int n_exp;
    bus.keys  = '0;
    bus7.keys = '0;

    // Reset state
    tick(2);
    checkOutput("rst_instr", 32'(bus.instruction), 0);
    checkOutput("rst_pulse", 32'(bus.instr_pulse), 0);
    checkOutput("rst_state", 32'(bus.key_state), 0);
    reset = 1'b0;

    // Reset mid-press
    applyStimulus(4'b0010, 7);
    checkOutput("pre_rst_instr", 32'(bus.instruction), 2);
    #3 reset = 1'b1;
    #1;
    checkOutput("midrst_instr", 32'(bus.instruction), 0);
    checkOutput("midrst_pulse", 32'(bus.instr_pulse), 0);
    checkOutput("midrst_state", 32'(bus.key_state), 0);
    tick(1);
    reset = 1'b0;
    tick(6);
    checkOutput("rerun_early", 32'(bus.instruction), 0);
    tick(1);
    checkOutput("rerun_instr", 32'(bus.instruction), 2);
    checkOutput("rerun_pulse", 32'(bus.instr_pulse), 1);
    applyStimulus(4'b0000, 8);
    checkOutput("rerun_release", 32'(bus.instruction), 0);

    // Single press of key 2
    pulse_cnt = 0;
    applyStimulus(4'b0100, 6);
    checkOutput("p2_keystate", 32'(bus.key_state), 4);
    checkOutput("p2_early", 32'(bus.instruction), 0);
    tick(1);
    checkOutput("p2_instr", 32'(bus.instruction), 3);
    checkOutput("p2_pulse", 32'(bus.instr_pulse), 1);
    tick(1);
    checkOutput("p2_pulse_off", 32'(bus.instr_pulse), 0);
    checkOutput("p2_hold", 32'(bus.instruction), 3);
    tick(22);
    applyStimulus(4'b0000, 6);
    checkOutput("p2_rel_early", 32'(bus.instruction), 3);
    tick(1);
    checkOutput("p2_rel", 32'(bus.instruction), 0);
    tick(3);
`ifdef KEYPROC_REPEAT_EN
    checkOutput("p2_npulse", 32'(pulse_cnt), 3);
`else
    checkOutput("p2_npulse", 32'(pulse_cnt), 1);
`endif

    // Glitch of DEBOUNCE_CYCLES-1 on key 1
    pulse_cnt = 0;
    applyStimulus(4'b0010, 3);
    bus.keys = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checkOutput("gl_keystate", 32'(bus.key_state), 0);
      checkOutput("gl_instr", 32'(bus.instruction), 0);
    end
    checkOutput("gl_npulse", 32'(pulse_cnt), 0);

    // Priority, no preemption, lockout
    applyStimulus(4'b1010, 7);
    checkOutput("pr_instr", 32'(bus.instruction), 2);
    checkOutput("pr_pulse", 32'(bus.instr_pulse), 1);
    tick(1);
    pulse_cnt = 0;
    applyStimulus(4'b1011, 10);
    checkOutput("pr_keystate", 32'(bus.key_state), 11);
    checkOutput("pr_nopreempt", 32'(bus.instruction), 2);
    applyStimulus(4'b1001, 7);
    checkOutput("lk_instr", 32'(bus.instruction), 0);
    tick(10);
    checkOutput("lk_still0", 32'(bus.instruction), 0);
    checkOutput("lk_npulse", 32'(pulse_cnt), 0);
    applyStimulus(4'b0000, 8);
    checkOutput("lk_rel_npulse", 32'(pulse_cnt), 0);
    applyStimulus(4'b1000, 7);
    checkOutput("k3_instr", 32'(bus.instruction), 4);
    checkOutput("k3_pulse", 32'(bus.instr_pulse), 1);
    tick(1);
    checkOutput("k3_npulse", 32'(pulse_cnt), 1);
    applyStimulus(4'b0000, 8);

    // Long hold of key 0
    pulse_q.delete();
    applyStimulus(4'b0001, 50);
    applyStimulus(4'b0000, 12);
    checkOutput("hold_instr_rel", 32'(bus.instruction), 0);
`ifdef KEYPROC_REPEAT_EN
    n_exp = 5;
`else
    n_exp = 1;
`endif
    checkOutput("hold_npulse", 32'(pulse_q.size()), 32'(n_exp));
    for (int k = 0; k < pulse_q.size() && k < n_exp; k++)
      checkOutput("hold_pulse_time", 32'(pulse_q[k] - pulse_q[0]), 32'(exp_rep[k]));

    // 7-key instance: highest index maps to code 7
    bus7.keys = 7'b1000000;
    tick(7);
    checkOutput("w7_instr", 32'(bus7.instruction), 7);
    checkOutput("w7_pulse", 32'(bus7.instr_pulse), 1);
    bus7.keys = 7'b0000000;
    tick(8);
    checkOutput("w7_rel", 32'(bus7.instruction), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
